// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - tx_state_t    : transmitter FSM state encoding
//   - DB_5..DB_8    : encoding of the 2-bit character-width select
//   - LINE_*        : serial line levels for idle, start and stop bits
//   - last_bit_idx  : index of the final data bit for a width select
//   - width_mask    : mask of the valid data bits for a width select
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT1  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } tx_state_t;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Width N = 5 + select, so the last bit index N-1 = select + 4 (fits 3 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    return 3'(db) + 3'd4;
  endfunction

  function automatic logic [7:0] width_mask(input logic [1:0] db);
    logic [7:0] m;
    case (db)
      DB_5:    m = 8'h1F;
      DB_6:    m = 8'h3F;
      DB_7:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_parity.sv
// -----------------------------------------------------------------------------
// uart_parity
// Combinational parity of the low N bits of a character (N = 5..8).
// Ports:
//   i_data      [7:0] character; bits above the selected width are ignored
//   i_data_bits [1:0] width select (00=5, 01=6, 10=7, 11=8)
//   i_odd             1 = odd parity, 0 = even parity
//   o_parity          parity bit to place on the line
// -----------------------------------------------------------------------------
module uart_parity
  import uart_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [1:0] i_data_bits,
  input  logic       i_odd,
  output logic       o_parity
);

  logic [7:0] w_masked;

  assign w_masked = i_data & width_mask(i_data_bits);
  // Even parity is the plain XOR; odd parity inverts it.
  assign o_parity = (^w_masked) ^ i_odd;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter driven by an external baud-tick generator.
// Frame: WAIT1 (line high, waits for the first tick) -> start bit ->
// N data bits -> optional parity -> one or two stop bits.
// Ports:
//   clk26m          26 MHz function clock
//   rst             synchronous active-high reset
//   tx_valid        host offers a character
//   tx_data  [7:0]  character (bits above the configured width ignored)
//   tx_ready        character accepted this cycle if tx_valid (state IDLE)
//   data_bits [1:0] width: 00=5, 01=6, 10=7, 11=8
//   parity_en       append parity bit
//   parity_odd      1 = odd, 0 = even parity
//   stop2           1 = two stop bits
//   tx_bpsclk       one-cycle bit tick from the baud generator
//   tx_bps_en       baud generator enable (high for the whole frame)
//   txd             registered serial line, idles high
//   tx_busy         frame in progress
//   tx_done         one-cycle pulse on return to IDLE after a full frame
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk26m,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic [1:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  input  logic       tx_bpsclk,
  output logic       tx_bps_en,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t  r_state;
  logic [7:0] r_data;
  logic [7:0] r_shift;
  logic [1:0] r_db;
  logic       r_pe;
  logic       r_po;
  logic       r_s2;
  logic [2:0] r_cnt;
  logic       r_txd;
  logic       r_bps_en;
  logic       r_done;

  logic       w_accept;
  logic       w_par;
  logic       w_cur_bit;
  logic [7:0] w_shift_nx;
  logic [7:0] w_load;
  logic [2:0] w_last;

  assign w_accept = tx_valid & tx_ready;
  assign w_last   = last_bit_idx(r_db);

  // The shift register always presents the next bit at one fixed end:
  // bit 0 for LSB-first, bit 7 for MSB-first. For MSB-first the character
  // is left-aligned at load so its top configured bit sits in bit 7.
  assign w_cur_bit  = LSB_FIRST ? r_shift[0] : r_shift[7];
  assign w_shift_nx = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
  assign w_load     = LSB_FIRST ? (tx_data & width_mask(data_bits))
                                : (tx_data << (3'd7 - last_bit_idx(data_bits)));

  uart_parity u_parity (
    .i_data      (r_data),
    .i_data_bits (r_db),
    .i_odd       (r_po),
    .o_parity    (w_par)
  );

  always_ff @(posedge clk26m) begin
    if (rst) begin
      r_state  <= IDLE;
      r_data   <= 8'h00;
      r_shift  <= 8'h00;
      r_db     <= 2'b00;
      r_pe     <= 1'b0;
      r_po     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= 3'd0;
      r_txd    <= LINE_IDLE;
      r_bps_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Ticks here are ignored; only an accepted character starts a frame.
          if (w_accept) begin
            r_data   <= tx_data & width_mask(data_bits);
            r_shift  <= w_load;
            r_db     <= data_bits;
            r_pe     <= parity_en;
            r_po     <= parity_odd;
            r_s2     <= stop2;
            r_cnt    <= 3'd0;
            r_bps_en <= 1'b1;
            r_txd    <= LINE_IDLE;
            r_state  <= WAIT1;
          end
        end
        WAIT1: begin
          if (tx_bpsclk) begin
            r_txd   <= LINE_START;
            r_state <= START;
          end
        end
        START: begin
          if (tx_bpsclk) begin
            r_txd   <= w_cur_bit;
            r_shift <= w_shift_nx;
            r_cnt   <= 3'd0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (tx_bpsclk) begin
            if (r_cnt == w_last) begin
              if (r_pe) begin
                r_txd   <= w_par;
                r_state <= PARITY;
              end else begin
                r_txd   <= LINE_STOP;
                r_state <= STOP1;
              end
            end else begin
              r_txd   <= w_cur_bit;
              r_shift <= w_shift_nx;
              r_cnt   <= r_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tx_bpsclk) begin
            r_txd   <= LINE_STOP;
            r_state <= STOP1;
          end
        end
        STOP1: begin
          if (tx_bpsclk) begin
            if (r_s2) begin
              r_state <= STOP2;
            end else begin
              r_state  <= IDLE;
              r_done   <= 1'b1;
              r_bps_en <= 1'b0;
            end
          end
        end
        STOP2: begin
          if (tx_bpsclk) begin
            r_state  <= IDLE;
            r_done   <= 1'b1;
            r_bps_en <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_txd    <= LINE_IDLE;
          r_bps_en <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = (r_state == IDLE);
  assign tx_busy   = (r_state != IDLE);
  assign txd       = r_txd;
  assign tx_bps_en = r_bps_en;
  assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx. Accepted characters are turned into the
// expected sequence of line levels (one per bit tick, WAIT1 included) by a
// frame-level model; a monitor samples txd at every tick of a frame and
// compares the collected frame on tx_done. Per-cycle line/handshake rules
// are checked alongside.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam bit LSB = 1'b1;

  logic       clk26m     = 1'b0;
  logic       rst        = 1'b1;
  logic       tx_valid   = 1'b0;
  logic [7:0] tx_data    = 8'h00;
  logic [1:0] data_bits  = 2'b00;
  logic       parity_en  = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop2      = 1'b0;
  logic       tx_bpsclk  = 1'b0;
  logic       tx_ready;
  logic       tx_bps_en;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(.LSB_FIRST(LSB)) dut (
    .clk26m     (clk26m),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx_bpsclk  (tx_bpsclk),
    .tx_bps_en  (tx_bps_en),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk26m = ~clk26m;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp    = 0;
  int     n_bad    = 0;
  int     tick_div = 16;
  bit     free_tick = 1'b0;
  bit     b2b_chk   = 1'b0;
  int     bcnt      = 0;

  // Baud generator: counts only while enabled (or forced free-running).
  always @(posedge clk26m) begin
    if (!tx_bps_en && !free_tick) begin
      bcnt      <= 0;
      tx_bpsclk <= 1'b0;
    end else if (bcnt >= tick_div - 1) begin
      bcnt      <= 0;
      tx_bpsclk <= 1'b1;
    end else begin
      bcnt      <= bcnt + 1;
      tx_bpsclk <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Line levels seen at each tick: WAIT1 high, start low, data, parity, stops.
  function automatic frame_t model(input logic [7:0] d, input logic [1:0] db,
                                   input logic pe, input logic po, input logic s2);
    frame_t f;
    int n, k, ones;
    f.bits = '0;
    n = 5 + int'(db);
    ones = 0;
    k = 0;
    f.bits[k] = 1'b1; k++;
    f.bits[k] = 1'b0; k++;
    for (int i = 0; i < n; i++) begin
      f.bits[k] = LSB ? d[i] : d[n-1-i];
      k++;
      ones += int'(d[i]);
    end
    if (pe) begin
      f.bits[k] = ((ones % 2) == 1) ^ po;
      k++;
    end
    f.bits[k] = 1'b1; k++;
    if (s2) begin
      f.bits[k] = 1'b1; k++;
    end
    f.len = k;
    return f;
  endfunction

  // Scoreboard feed: a character visible with tx_ready at this negedge is
  // accepted on the next posedge. A reset edge discards any in-flight frame.
  logic push_rst_p = 1'b1;
  initial begin
    forever begin
      @(negedge clk26m);
      if (push_rst_p) exp_q.delete();
      if (tx_valid && tx_ready && !rst)
        exp_q.push_back(model(tx_data, data_bits, parity_en, parity_odd, stop2));
      push_rst_p = rst;
    end
  end

  // Monitor
  logic   m_rst_p  = 1'b1;
  logic   m_tick_p = 1'b0;
  logic   m_busy_p = 1'b0;
  logic   m_txd_p  = 1'b1;
  frame_t got;
  frame_t e;
  initial begin
    got.bits = '0;
    got.len  = 0;
    forever begin
      @(negedge clk26m);
      chk("ready_vs_state", tx_ready, !tx_busy);
      chk("bps_en_vs_busy", tx_bps_en, tx_busy);
      if (!tx_busy) chk("idle_line_high", txd, 1'b1);
      chk("done_pulse", tx_done, m_busy_p && !tx_busy && !m_rst_p);
      if (!m_tick_p && !m_rst_p) chk("txd_stable_between_ticks", txd, m_txd_p);
      if (m_rst_p) begin
        chk("rst_txd", txd, 1'b1);
        chk("rst_bps_en", tx_bps_en, 1'b0);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        got.bits = '0;
        got.len  = 0;
      end
      if (tx_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_unexpected: got tx_done, expected no frame (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("frame_len", got.len, e.len);
          chk("frame_bits", 32'(got.bits), 32'(e.bits));
        end
        got.bits = '0;
        got.len  = 0;
      end
      if (tx_bpsclk && tx_busy && !rst) begin
        if (got.len < 16) got.bits[got.len] = txd;
        got.len++;
      end
      m_rst_p  = rst;
      m_tick_p = tx_bpsclk;
      m_busy_p = tx_busy;
      m_txd_p  = txd;
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] db, input logic pe,
                      input logic po, input logic s2, input bit scramble);
    int t;
    t = 0;
    tx_data    = d;
    data_bits  = db;
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    tx_valid   = 1'b1;
    while (!tx_ready && t < 3000) begin
      @(posedge clk26m); #2;
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got tx_ready=0, expected 1 within 3000 cycles");
      tx_valid = 1'b0;
      return;
    end
    if (b2b_chk) chk("b2b_accept_in_done_cycle", tx_done, 1'b1);
    @(posedge clk26m); #2;
    tx_valid = 1'b0;
    if (scramble) begin
      tx_data    = 8'($urandom);
      data_bits  = 2'($urandom_range(3, 0));
      parity_en  = 1'($urandom_range(1, 0));
      parity_odd = 1'($urandom_range(1, 0));
      stop2      = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (tx_busy && t < 5000) begin
      @(posedge clk26m); #2;
      t++;
    end
    if (t >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got tx_busy=1, expected 0 within 5000 cycles");
    end
  endtask

  task automatic wait_ticks(input int n);
    int t, left;
    t = 0;
    left = n;
    while (left > 0 && t < 5000) begin
      @(posedge clk26m); #2;
      if (tx_bpsclk) left--;
      t++;
    end
    if (left > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: got %0d ticks, expected %0d", n - left, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk26m);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk26m);
    #2;

    // 8N1 0x55 at 16 cycles per bit
    tick_div = 16;
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // 7-bit parity cases
    send(8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send(8'h03, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send(8'h03, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // 5 bits, two stop bits
    send(8'hE1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle();

    // Three characters with tx_valid held high
    tick_div = 4;
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    b2b_chk = 1'b1;
    send(8'h3C, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h81, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    b2b_chk = 1'b0;
    wait_idle();

    // Ticks in IDLE, then inputs scrambled right after acceptance
    free_tick = 1'b1;
    repeat (20) @(posedge clk26m);
    #2;
    free_tick = 1'b0;
    repeat (3) @(posedge clk26m);
    #2;
    send(8'h96, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Reset during the data phase, then a clean character
    tick_div = 8;
    send(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ticks(3);
    @(posedge clk26m); #2;
    rst = 1'b1;
    @(posedge clk26m); #2;
    rst = 1'b0;
    send(8'h5A, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // Randomized frames, some back-to-back
    for (int i = 0; i < 40; i++) begin
      tick_div = int'($urandom_range(6, 2));
      send(8'($urandom), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) != 0) wait_idle();
    end
    wait_idle();
    repeat (5) @(posedge clk26m);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
